aurora_reset_sequencer: RTL and testbench

- Shares one "reset sequence in flight" resource across NLINKS Aurora links: at most one link's reset block (ext_reset / reset_busy pair) is driven at any time.
- Collects software reset requests and link-down watchdog expirations into per-link pending flags, then grants them round-robin.
- Per link: assert ext_reset, wait for reset_busy to assert and then clear, enforce a holdoff, move on.
- Sits in the init_clk domain above the per-link reset blocks; all inputs are already synchronous to clk_i.

---
 rtl/aurora_reset_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_aurora_reset_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_reset_sequencer.sv
// Round-robin reset sequencer shared across NLINKS Aurora links.
// At most one link's ext_reset/reset_busy handshake is in flight at a time.
// Optional per-link grant counters are enabled by defining AURORA_RESET_SEQ_STATS_EN.
module aurora_reset_sequencer #(
    parameter int unsigned NLINKS       = 4,
    parameter logic [31:0] DOWN_TIMEOUT = 32'd200000000,
    parameter logic [15:0] ACK_TIMEOUT  = 16'd64,
    parameter logic [31:0] HOLDOFF      = 32'd2000000,
    parameter int unsigned PTR_W        = (NLINKS > 1) ? $clog2(NLINKS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                enable_i,
    input  logic [NLINKS-1:0]   link_up_i,
    input  logic [NLINKS-1:0]   reset_req_i,
    input  logic [NLINKS-1:0]   reset_busy_i,
    input  logic                err_clear_i,
    output logic [NLINKS-1:0]   ext_reset_o,
    output logic                active_o,
    output logic [PTR_W-1:0]    active_link_o,
    output logic [NLINKS-1:0]   pending_o,
`ifdef AURORA_RESET_SEQ_STATS_EN
    output logic [8*NLINKS-1:0] reset_count_o,
`endif
    output logic [NLINKS-1:0]   ack_err_o
);

    typedef enum logic [1:0] {StIdle, StAssert, StWaitDone, StHoldoff} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  link_q, link_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [NLINKS-1:0] pending_q, pending_d;
    logic [NLINKS-1:0] ack_err_q, ack_err_d;
    logic [15:0]       ack_cnt_q, ack_cnt_d;
    logic [31:0]       hold_cnt_q, hold_cnt_d;
    logic [31:0]       wd_q [NLINKS];
    logic [31:0]       wd_d [NLINKS];
    logic [NLINKS-1:0] wd_fire;
    logic [NLINKS-1:0] own_link;
    logic              grant;
    logic [PTR_W-1:0]  grant_idx;
    logic              found_hi, found_lo;
    logic [PTR_W-1:0]  idx_hi, idx_lo;

    // Round-robin pick: lowest pending index above rr pointer, else lowest at/below it
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NLINKS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                if (i > int'(rr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = PTR_W'(i);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = PTR_W'(i);
                end
            end
        end
        grant_idx = found_hi ? idx_hi : idx_lo;
        grant     = (state_q == StIdle) && enable_i && (|pending_q);
    end

    // Per-link watchdogs and pending flags; a grant clear beats a same-cycle set
    always_comb begin
        pending_d = pending_q;
        wd_fire   = '0;
        own_link  = '0;
        for (int i = 0; i < NLINKS; i++) begin
            wd_d[i]     = '0;
            own_link[i] = (state_q != StIdle) && (link_q == PTR_W'(i));
            if (!link_up_i[i] && enable_i && !pending_q[i] && !own_link[i]) begin
                if (wd_q[i] == DOWN_TIMEOUT - 32'd1) begin
                    wd_fire[i] = 1'b1;
                end else begin
                    wd_d[i] = wd_q[i] + 32'd1;
                end
            end
            if ((reset_req_i[i] || wd_fire[i]) && !own_link[i]) begin
                pending_d[i] = 1'b1;
            end
            if (grant && (grant_idx == PTR_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Sequencer next state; ack error set takes priority over err_clear_i
    always_comb begin
        state_d    = state_q;
        link_d     = link_q;
        rr_d       = rr_q;
        ack_cnt_d  = '0;
        hold_cnt_d = '0;
        ack_err_d  = err_clear_i ? '0 : ack_err_q;
        case (state_q)
            StIdle: begin
                if (grant) begin
                    link_d  = grant_idx;
                    rr_d    = grant_idx;
                    state_d = StAssert;
                end
            end
            StAssert: begin
                if (reset_busy_i[link_q]) begin
                    state_d = StWaitDone;
                end else if (ack_cnt_q == ACK_TIMEOUT - 16'd1) begin
                    ack_err_d[link_q] = 1'b1;
                    state_d           = StHoldoff;
                end else begin
                    ack_cnt_d = ack_cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (!reset_busy_i[link_q]) begin
                    state_d = StHoldoff;
                end
            end
            StHoldoff: begin
                if ((HOLDOFF == 32'd0) || (hold_cnt_q == HOLDOFF - 32'd1)) begin
                    state_d = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output decode; ext_reset follows the ASSERT state only
    always_comb begin
        ext_reset_o = '0;
        if (state_q == StAssert) begin
            ext_reset_o[link_q] = 1'b1;
        end
        active_o      = (state_q != StIdle);
        active_link_o = link_q;
        pending_o     = pending_q;
        ack_err_o     = ack_err_q;
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StIdle;
            link_q     <= '0;
            rr_q       <= PTR_W'(NLINKS - 1);
            pending_q  <= '0;
            ack_err_q  <= '0;
            ack_cnt_q  <= '0;
            hold_cnt_q <= '0;
            for (int i = 0; i < NLINKS; i++) begin
                wd_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            link_q     <= link_d;
            rr_q       <= rr_d;
            pending_q  <= pending_d;
            ack_err_q  <= ack_err_d;
            ack_cnt_q  <= ack_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            for (int i = 0; i < NLINKS; i++) begin
                wd_q[i] <= wd_d[i];
            end
        end
    end

`ifdef AURORA_RESET_SEQ_STATS_EN
    logic [7:0] cnt_q [NLINKS];
    logic [7:0] cnt_d [NLINKS];

    // Saturating grant counters; clear beats increment
    always_comb begin
        reset_count_o = '0;
        for (int i = 0; i < NLINKS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (err_clear_i) begin
                cnt_d[i] = '0;
            end else if (grant && (grant_idx == PTR_W'(i)) && (cnt_q[i] != 8'hFF)) begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
            reset_count_o[8*i +: 8] = cnt_q[i];
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NLINKS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NLINKS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// Directed bench for aurora_reset_sequencer (NLINKS=4, short timeouts).
module tb_aurora_reset_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] link_up = 4'hF;
    logic [3:0] reset_req = 4'h0;
    logic [3:0] busy = 4'h0;
    logic       err_clear = 1'b0;
    logic [3:0] ext_reset;
    logic       active;
    logic [1:0] active_link;
    logic [3:0] pending;
    logic [3:0] ack_err;
`ifdef AURORA_RESET_SEQ_STATS_EN
    logic [31:0] reset_count;
`endif

    aurora_reset_sequencer #(
        .NLINKS      (4),
        .DOWN_TIMEOUT(32'd100),
        .ACK_TIMEOUT (16'd64),
        .HOLDOFF     (32'd8)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .link_up_i    (link_up),
        .reset_req_i  (reset_req),
        .reset_busy_i (busy),
        .err_clear_i  (err_clear),
        .ext_reset_o  (ext_reset),
        .active_o     (active),
        .active_link_o(active_link),
        .pending_o    (pending),
`ifdef AURORA_RESET_SEQ_STATS_EN
        .reset_count_o(reset_count),
`endif
        .ack_err_o    (ack_err)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Link reset-block model: busy rises 2 negedges after ext_reset seen, drops 10 later
    logic [3:0] mute = 4'h0;
    int mcnt [4];
    always @(negedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                mcnt[i] = 0;
            end else if (mcnt[i] == 0) begin
                if (ext_reset[i] && !mute[i]) mcnt[i] = 1;
            end else begin
                mcnt[i] = mcnt[i] + 1;
                if (mcnt[i] == 12) mcnt[i] = 0;
            end
            busy[i] = (mcnt[i] >= 2);
        end
    end

    // Monitor: grant log, ext_reset pulse lengths, multi-hot detection
    int   glog[$];
    int   gcyc[$];
    logic prev_act = 1'b0;
    logic multi_hot = 1'b0;
    int   len [4] = '{0, 0, 0, 0};
    int   last_len [4] = '{0, 0, 0, 0};
    always @(negedge clk_i) begin
        if ($countones(ext_reset) > 1) multi_hot = 1'b1;
        if (active && !prev_act) begin
            glog.push_back(int'(active_link));
            gcyc.push_back(cyc);
        end
        prev_act = active;
        for (int i = 0; i < 4; i++) begin
            if (ext_reset[i]) begin
                len[i] = len[i] + 1;
            end else if (len[i] != 0) begin
                last_len[i] = len[i];
                len[i] = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] m);
        reset_req = m;
        tick(1);
        reset_req = 4'h0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        tick(1);
        while ((active || (pending != 4'h0)) && k < budget) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(active | (|pending)), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        int exp_order [9] = '{3, 0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state
        tick(3);
        chk("rst_ext_reset", 32'(ext_reset), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_active_link", 32'(active_link), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_ack_err", 32'(ack_err), 32'h0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick(2);

        // Two requests: link 1 first, then link 3
        pulse_req(4'b1010);
        chk("t1_pending", 32'(pending), 32'hA);
        tick(1);
        chk("t1_grant_link", 32'(active_link), 32'd1);
        chk("t1_ext_reset", 32'(ext_reset), 32'h2);
        chk("t1_pending_after", 32'(pending), 32'h8);
        wait_idle("t1_idle", 200);
        chk("t1_ngrants", 32'(glog.size()), 32'd2);
        chk("t1_order1", 32'(glog[1]), 32'd3);
        chk("t1_gap", 32'(gcyc[1] - gcyc[0]), 32'd21);
        chk("t1_len1", 32'(last_len[1]), 32'd2);
        chk("t1_len3", 32'(last_len[3]), 32'd2);

        // Watchdog on link 2
        enable = 1'b0;
        link_up[2] = 1'b0;
        tick(3);
        chk("t2_wd_held", 32'(pending), 32'h0);
        enable = 1'b1;
        tick(99);
        chk("t2_wd_early", 32'(pending), 32'h0);
        tick(1);
        chk("t2_wd_fire", 32'(pending), 32'h4);
        tick(1);
        chk("t2_grant_link", 32'(active_link), 32'd2);
        chk("t2_pending_clr", 32'(pending), 32'h0);
        k = 0;
        while (active && k < 200) begin
            tick(1);
            k++;
        end
        chk("t2_seq_done", 32'(active), 32'd0);
        tick(99);
        chk("t2_wd_restart_early", 32'(pending), 32'h0);
        tick(1);
        chk("t2_wd_restart_fire", 32'(pending), 32'h4);
        link_up[2] = 1'b1;
        wait_idle("t2_idle", 200);

        // Link 0 never acks
        mute[0] = 1'b1;
        glog.delete();
        pulse_req(4'b0001);
        wait_idle("t3_idle", 300);
        chk("t3_grant", 32'(glog[0]), 32'd0);
        chk("t3_len0", 32'(last_len[0]), 32'd64);
        chk("t3_ack_err", 32'(ack_err), 32'h1);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("t3_err_clear", 32'(ack_err), 32'h0);
        mute[0] = 1'b0;

        // Round-robin with wrap-around
        glog.delete();
        pulse_req(4'b1000);
        wait_idle("t4_idle_a", 200);
        pulse_req(4'b1111);
        wait_idle("t4_idle_b", 500);
        pulse_req(4'b1111);
        wait_idle("t4_idle_c", 500);
        chk("t4_ngrants", 32'(glog.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < glog.size()) chk("t4_order", 32'(glog[i]), 32'(exp_order[i]));
        end

        // Request for active link ignored; async reset mid-WAIT_DONE
        pulse_req(4'b0010);
        k = 0;
        while (!(active && ext_reset == 4'h0) && k < 20) begin
            tick(1);
            k++;
        end
        chk("t5_wait_link", 32'(active_link), 32'd1);
        pulse_req(4'b0110);
        chk("t5_pending", 32'(pending), 32'h4);
        chk("t5_still_active", 32'(active), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ext_reset", 32'(ext_reset), 32'h0);
        chk("t5_rst_active", 32'(active), 32'h0);
        chk("t5_rst_active_link", 32'(active_link), 32'h0);
        chk("t5_rst_pending", 32'(pending), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        pulse_req(4'b0101);
        tick(1);
        chk("t5_rr_reset", 32'(active_link), 32'd0);
        wait_idle("t5_idle", 300);

`ifdef AURORA_RESET_SEQ_STATS_EN
        chk("s_cnt0", 32'(reset_count[7:0]), 32'd1);
        chk("s_cnt1", 32'(reset_count[15:8]), 32'd0);
        chk("s_cnt2", 32'(reset_count[23:16]), 32'd1);
        for (int i = 0; i < 300; i++) begin
            pulse_req(4'b1000);
            wait_idle("s_idle", 100);
        end
        chk("s_cnt3_sat", 32'(reset_count[31:24]), 32'd255);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("s_clear", reset_count, 32'h0);
`endif

        chk("onehot_ext_reset", 32'(multi_hot), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
